decode_register_queue: RTL and testbench

DECODE_REGISTER_QUEUE -- requirements
Module: decode_register_queue

---
 rtl/decode_register_queue.sv | 145 ++++++++++++++
 tb/tb_decode_register_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_register_queue.sv
// Decodes x86 register fields per channel at push time and queues the one-hot results in a DEPTH-entry FIFO.
// Optional macro DECODE_REGISTER_QUEUE_SREG_EN adds segment-register decoding (in_sreg_sel / out_sreg).
module decode_register_queue #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3*CHANNELS-1:0]        in_reg,
  input  logic                         bit_width_16,
  input  logic                         bit_width_32,
  input  logic                         w_is_present,
  input  logic                         w,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [24*CHANNELS-1:0]       out_onehot,
  output logic [2*CHANNELS-1:0]        out_size,
  output logic [CHANNELS-1:0]          out_err,
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
  input  logic [CHANNELS-1:0]          in_sreg_sel,
  output logic [8*CHANNELS-1:0]        out_sreg,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [24*CHANNELS-1:0] dec_onehot;
  logic [2*CHANNELS-1:0]  dec_size;
  logic [CHANNELS-1:0]    dec_err;
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
  logic [8*CHANNELS-1:0]  dec_sreg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_dec
      logic [2:0]  r;
      logic [23:0] oh_c;
      logic [1:0]  sz_c;
      logic        er_c;
      logic [7:0]  sr_c;

      assign r = in_reg[3*gi +: 3];

      always_comb begin
        oh_c = '0;
        sz_c = 2'b01;
        er_c = 1'b0;
        sr_c = '0;
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
        if (in_sreg_sel[gi]) begin
          if (r <= 3'd5) sr_c[r] = 1'b1;
          else           er_c    = 1'b1;
        end else
`endif
        // Explicit byte form wins, then dword over word when both width bits are set
        if (w_is_present && !w) begin
          sz_c = 2'b00;
          oh_c[{2'b00, r}] = 1'b1;
        end else if (bit_width_32) begin
          sz_c = 2'b10;
          oh_c[{2'b10, r}] = 1'b1;
        end else if (bit_width_16) begin
          sz_c = 2'b01;
          oh_c[{2'b01, r}] = 1'b1;
        end else begin
          er_c = 1'b1;
        end
      end

      assign dec_onehot[24*gi +: 24] = oh_c;
      assign dec_size[2*gi +: 2]     = sz_c;
      assign dec_err[gi]             = er_c;
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
      assign dec_sreg[8*gi +: 8]     = sr_c;
`endif
    end
  endgenerate

  logic [24*CHANNELS-1:0] onehot_mem [DEPTH];
  logic [2*CHANNELS-1:0]  size_mem   [DEPTH];
  logic [CHANNELS-1:0]    err_mem    [DEPTH];
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
  logic [8*CHANNELS-1:0]  sreg_mem   [DEPTH];
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  assign in_ready  = (level_q < LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign level     = level_q;

  // DEPTH is a power of two, so pointer increments wrap naturally
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      onehot_mem[wr_ptr_q] <= dec_onehot;
      size_mem[wr_ptr_q]   <= dec_size;
      err_mem[wr_ptr_q]    <= dec_err;
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
      sreg_mem[wr_ptr_q]   <= dec_sreg;
`endif
    end
  end

  // Empty queue presents all-zero payload instead of stale storage
  assign out_onehot = out_valid ? onehot_mem[rd_ptr_q] : '0;
  assign out_size   = out_valid ? size_mem[rd_ptr_q]   : '0;
  assign out_err    = out_valid ? err_mem[rd_ptr_q]    : '0;
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
  assign out_sreg   = out_valid ? sreg_mem[rd_ptr_q]   : '0;
`endif

endmodule

// File: tb/tb_decode_register_queue.sv
// Scoreboard bench for decode_register_queue: driver pushes model results on accept, monitor pops and compares.
module tb_decode_register_queue;
  localparam int CH = 2;
  localparam int DEPTH = 2;
  localparam int LW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [24*CH-1:0] oh;
    logic [2*CH-1:0]  sz;
    logic [CH-1:0]    err;
    logic [8*CH-1:0]  sr;
  } exp_t;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, bit_width_16, bit_width_32, w_is_present, w;
  logic out_valid, out_ready;
  logic [3*CH-1:0]  in_reg;
  logic [24*CH-1:0] out_onehot;
  logic [2*CH-1:0]  out_size;
  logic [CH-1:0]    out_err;
  logic [LW-1:0]    level;
  logic [CH-1:0]    sel_drv;
  logic [8*CH-1:0]  sreg_mon;
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
  logic [CH-1:0]    in_sreg_sel;
  logic [8*CH-1:0]  out_sreg;
  assign in_sreg_sel = sel_drv;
  assign sreg_mon    = out_sreg;
`else
  assign sreg_mon    = '0;
`endif

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  decode_register_queue #(.CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .bit_width_16(bit_width_16), .bit_width_32(bit_width_32),
    .w_is_present(w_is_present), .w(w), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_size(out_size), .out_err(out_err),
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
    .in_sreg_sel(in_sreg_sel), .out_sreg(out_sreg),
`endif
    .level(level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: size class picks an 8-bit bank (byte/word/dword), register number picks the bit in it
  function automatic exp_t model(input logic [3*CH-1:0] regs, input logic b16, input logic b32,
                                 input logic wp, input logic wv, input logic [CH-1:0] sel);
    exp_t e = '0;
    for (int c = 0; c < CH; c++) begin
      int r = int'(regs[3*c +: 3]);
      int bank;
      bank = -1;
      if (sel[c]) begin
        e.sz[2*c +: 2] = 2'd1;
        if (r < 6) e.sr[8*c + r] = 1'b1;
        else       e.err[c] = 1'b1;
      end else begin
        if (wp && !wv)  bank = 0;
        else if (b32)   bank = 2;
        else if (b16)   bank = 1;
        if (bank < 0) begin
          e.sz[2*c +: 2] = 2'd1;
          e.err[c] = 1'b1;
        end else begin
          e.sz[2*c +: 2] = 2'(bank);
          e.oh[24*c + 8*bank + r] = 1'b1;
        end
      end
    end
    return e;
  endfunction

  // One clock of stimulus; the expected entry enters the scoreboard at the edge that accepts it
  task automatic step(input logic v, input logic [3*CH-1:0] r, input logic b16, input logic b32,
                      input logic wp, input logic wv, input logic [CH-1:0] sel,
                      input logic ordy, input logic rst);
    logic acc;
    exp_t e;
    in_valid = v; in_reg = r; bit_width_16 = b16; bit_width_32 = b32;
    w_is_present = wp; w = wv; sel_drv = sel; out_ready = ordy; reset = rst;
    e = model(r, b16, b32, wp, wv, sel);
    @(negedge clock);
    acc = v && in_ready && !rst;
    @(posedge clock);
    if (rst) exp_q.delete();
    else if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, ordy, 1'b0);
  endtask

  // Monitor: compares DUT state and head entry against the scoreboard every cycle
  initial begin
    forever begin
      exp_t h;
      @(negedge clock);
      if (reset !== 1'b1 && tests >= 0) begin
        check("level", 64'(level), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
        if (exp_q.size() == 0) begin
          check("empty_payload", 64'({out_onehot, out_size, out_err, sreg_mon}), 64'd0);
        end else begin
          h = exp_q[0];
          check("head_onehot", 64'(out_onehot), 64'(h.oh));
          check("head_size", 64'(out_size), 64'(h.sz));
          check("head_err", 64'(out_err), 64'(h.err));
          check("head_sreg", 64'(sreg_mon), 64'(h.sr));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [CH-1:0] sel_en;
`ifdef DECODE_REGISTER_QUEUE_SREG_EN
    sel_en = '1;
`else
    sel_en = '0;
`endif
    sel_drv = '0;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // EBX / EDI dword decode
    step(1'b1, {3'd7, 3'd3}, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("dword_valid", 64'(out_valid), 64'd1);
    check("dword_ch0_ebx", 64'(out_onehot[23:0]), 64'(24'h1 << 19));
    check("dword_ch1_edi", 64'(out_onehot[47:24]), 64'(24'h1 << 23));
    check("dword_size", 64'(out_size), 64'b1010);
    idle(1'b1);

    // AH byte, then SP word
    step(1'b1, {3'd0, 3'd4}, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("byte_ah", 64'(out_onehot[23:0]), 64'h10);
    check("byte_size", 64'(out_size[1:0]), 64'd0);
    idle(1'b1);
    step(1'b1, {3'd0, 3'd4}, 1'b1, 1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0);
    check("word_sp", 64'(out_onehot[23:0]), 64'(24'h1 << 12));
    check("word_size", 64'(out_size[1:0]), 64'd1);
    idle(1'b1);

    // No size attribute at all
    step(1'b1, {3'd2, 3'd5}, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("inval_onehot", 64'(out_onehot), 64'd0);
    check("inval_err", 64'(out_err), 64'b11);
    check("inval_size", 64'(out_size), 64'b0101);
    idle(1'b1);

    // Fill with consumer stalled, third push blocked, then drain
    for (int i = 0; i < 3; i++)
      step(1'b1, 6'(i * 9 + 1), 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("full_level", 64'(level), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("full_pop_blocks_push", 64'(level), 64'd1);
    idle(1'b1);
    check("drain_level", 64'(level), 64'd0);

    // Steady state at level 1 with concurrent push and pop
    step(1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 6'(i * 7 + 3), 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("pushpop_level", 64'(level), 64'd1);
    end
    idle(1'b1);

    // Reset while full discards everything
    step(1'b1, 6'd1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 6'd3, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);

`ifdef DECODE_REGISTER_QUEUE_SREG_EN
    step(1'b1, {3'd0, 3'd5}, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    check("sreg_gs", 64'(out_sreg[7:0]), 64'h20);
    check("sreg_gs_oh", 64'(out_onehot[23:0]), 64'd0);
    idle(1'b1);
    step(1'b1, {3'd0, 3'd6}, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    check("sreg_bad_err", 64'(out_err[0]), 64'd1);
    idle(1'b1);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), CH'($urandom) & sel_en,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
